// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-channel round-robin arbiter.
// Contents: channel count, select width, channel index type and the
// rotating-priority search used to choose the next winner.
package rr_arb_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef struct packed {
    logic    found;
    ch_idx_t idx;
  } pick_t;

  // Search valid[] starting just after 'last', wrapping 7->0. The loop runs
  // from lowest to highest priority so the highest-priority hit is the last
  // assignment made. Offset NUM_CH lands back on 'last' (lowest priority).
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] valid,
                                    input ch_idx_t           last);
    pick_t   p;
    ch_idx_t c;
    p = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      c = last + ch_idx_t'(k);
      if (valid[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arb_8to1_mux.sv
// 8:1 data multiplexer driven by the arbiter's grant index.
// Ports:
//   i_sel      3-bit select
//   i_d0..i_d7 WIDTH-bit data inputs
//   o_y        selected data
module mux_8to1 #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  logic [WIDTH-1:0] i_d4,
  input  logic [WIDTH-1:0] i_d5,
  input  logic [WIDTH-1:0] i_d6,
  input  logic [WIDTH-1:0] i_d7,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      3'd0: o_y = i_d0;
      3'd1: o_y = i_d1;
      3'd2: o_y = i_d2;
      3'd3: o_y = i_d3;
      3'd4: o_y = i_d4;
      3'd5: o_y = i_d5;
      3'd6: o_y = i_d6;
      3'd7: o_y = i_d7;
      default: o_y = i_d0;
    endcase
  end

endmodule

// File: rtl/rr_arb_8to1.sv
// Round-robin arbiter feeding a one-entry registered output stream.
// Eight valid/ready sources compete; the winner's word passes through the
// 8:1 mux and is captured with its source index.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   per-channel word available
//   in_data    [7:0][WIDTH-1:0] channel data
//   in_ready   one-hot or zero; channel accepted this cycle
//   out_valid  output register holds a word
//   out_data   registered selected word
//   out_src    source channel of out_data
//   out_ready  downstream accepts when out_valid & out_ready
module rr_arb_8to1
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             in_valid,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  in_data,
  output logic [NUM_CH-1:0]             in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [SEL_W-1:0]              out_src,
  input  logic                          out_ready
);

  logic               r_vld_p1;
  logic [WIDTH-1:0]   r_data_p1;
  ch_idx_t            r_src_p1;
  ch_idx_t            r_last_grant;

  logic               w_load_en;
  pick_t              w_pick;
  logic [NUM_CH-1:0]  w_in_ready;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_mux_data;

  // Stage p0: arbitration and data select
  assign w_load_en = !r_vld_p1 || out_ready;
  assign w_pick    = rr_pick(in_valid, r_last_grant);

  // in_ready is gated by rst_n so no source sees an acceptance during reset.
  always_comb begin
    w_in_ready = '0;
    if (rst_n && w_load_en && w_pick.found) begin
      w_in_ready[w_pick.idx] = 1'b1;
    end
  end

  assign w_xfer = |(in_valid & w_in_ready);

  mux_8to1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_sel (w_pick.idx),
    .i_d0  (in_data[0]),
    .i_d1  (in_data[1]),
    .i_d2  (in_data[2]),
    .i_d3  (in_data[3]),
    .i_d4  (in_data[4]),
    .i_d5  (in_data[5]),
    .i_d6  (in_data[6]),
    .i_d7  (in_data[7]),
    .o_y   (w_mux_data)
  );

  // Stage p1: output register and priority pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_data_p1    <= '0;
      r_src_p1     <= '0;
      r_last_grant <= ch_idx_t'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_vld_p1     <= 1'b1;
      r_data_p1    <= w_mux_data;
      r_src_p1     <= w_pick.idx;
      r_last_grant <= w_pick.idx;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1     <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_src   = r_src_p1;

endmodule

// File: tb/tb_rr_arb_8to1.sv
module tb_rr_arb_8to1;

  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic [7:0]            in_valid;
  logic [7:0][WIDTH-1:0] in_data;
  logic [7:0]            in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [2:0]            out_src;
  logic                  out_ready;

  rr_arb_8to1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: held output word and the last granted channel.
  logic             m_vld;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_last;
  int               acc_ch;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic int model_winner(input logic [7:0] v, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (v[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic cyc();
    int         g;
    logic [7:0] er;
    @(negedge clk);
    g  = model_winner(in_valid, m_last);
    er = 8'h00;
    if (rst_n && (!m_vld || out_ready) && g >= 0) er[g] = 1'b1;
    chk("in_ready", {56'd0, in_ready}, {56'd0, er});
    acc_ch = -1;
    if (!rst_n) begin
      m_vld = 1'b0; m_data = '0; m_src = 0; m_last = 7;
    end else if (er != 8'h00) begin
      m_vld = 1'b1; m_data = in_data[g]; m_src = g; m_last = g; acc_ch = g;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_vld});
    chk("out_src",   {61'd0, out_src},   64'(m_src));
    chk("out_data",  {32'd0, out_data},  {32'd0, m_data});
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cyc();
    rst_n = 1'b1;
  endtask

  logic [7:0] src_v;

  initial begin
    m_vld = 1'b0; m_data = '0; m_src = 0; m_last = 7; acc_ch = -1;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i] = $urandom;

    // Reset state
    do_reset(2);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  {32'd0, out_data},  64'd0);
    chk("rst_out_src",   {61'd0, out_src},   64'd0);

    // Single source on channel 2
    in_valid = 8'b0000_0100; in_data[2] = 32'hDEAD_BEEF; out_ready = 1'b1;
    #1;
    chk("single_in_ready", {56'd0, in_ready}, 64'h04);
    cyc();
    in_valid = '0;
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_data",  {32'd0, out_data},  64'hDEAD_BEEF);
    chk("single_src",   {61'd0, out_src},   64'd2);

    // All-request rotation from a fresh pointer
    do_reset(1);
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rot_src",   {61'd0, out_src},   64'(i % 8));
      chk("rot_valid", {63'd0, out_valid}, 64'd1);
    end

    // Idle retains priority: grant 3, idle, then channels 0 and 3
    do_reset(1);
    in_valid = 8'b0000_1000; cyc();
    in_valid = '0;
    for (int i = 0; i < 5; i++) cyc();
    in_valid = 8'b0000_1001; cyc();
    chk("idle_src", {61'd0, out_src}, 64'd0);
    in_valid = '0;

    // Reset during a stall, then 0x88 grants channel 3 first
    in_valid = 8'hFF; out_ready = 1'b0; cyc(); cyc();
    do_reset(1);
    chk("rst_stall_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall_data",  {32'd0, out_data},  64'd0);
    chk("rst_stall_src",   {61'd0, out_src},   64'd0);
    in_valid = 8'h88; out_ready = 1'b1; cyc();
    chk("rst_stall_first", {61'd0, out_src}, 64'd3);
    in_valid = '0; cyc();

    // Randomized traffic obeying the source hold rule
    src_v = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 8; c++) begin
        if (!src_v[c] && ($urandom_range(0, 2) == 0)) begin
          src_v[c]   = 1'b1;
          in_data[c] = $urandom;
        end
      end
      in_valid  = src_v;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cyc();
      if (acc_ch >= 0) src_v[acc_ch] = 1'b0;
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_8to1.md
Name: rr_arb_8to1

Overview:
- Round-robin arbiter and output stage that sits directly upstream of the 8:1 data mux.
- Each of 8 source channels offers WIDTH-bit words over valid/ready.
- The block picks one channel per transfer and drives the existing 8:1 mux select with the winning index.
- The selected word is captured into a one-entry output register presented as a valid/ready stream tagged with its source index.

Parameters:
- WIDTH, 32, data width per channel and of out_data.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  8  per-channel word available; bit i = channel i
- in_data  input  8 x WIDTH  packed array [7:0][WIDTH-1:0]; channel i data
- in_ready  output  8  one-hot or zero; bit i high = channel i word accepted this cycle
- out_valid  output  1  out_data/out_src hold a valid word
- out_data  output  WIDTH  registered selected word
- out_src  output  3  channel index that produced out_data
- out_ready  input  1  downstream accepts the word when out_valid & out_ready

Behaviour:
- Reset: synchronous, sampled on the clk rising edge while rst_n=0.
  - Clears out_valid=0, out_data=0, out_src=0, last_grant=7, so channel 0 has first priority.
  - in_ready is forced to 0 while rst_n=0.
  - Reset during a held word discards that word; no partial state survives.
- load_en (combinational) = !out_valid | out_ready. The output register is free or draining this cycle.
- Grant (combinational):
  - Search in_valid starting at index (last_grant+1) mod 8, wrapping 7->0.
  - The first set bit wins and becomes grant_idx (3 bits).
  - If no in_valid bit is set, there is no grant.
- in_ready[i] = load_en & any_valid & (grant_idx==i). At most one bit is set.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On that clk edge:
  - out_data <= in_data[grant_idx], routed through the 8:1 mux with sel=grant_idx.
  - out_src <= grant_idx.
  - out_valid <= 1.
  - last_grant <= grant_idx.
- Drain without load: out_valid & out_ready with no grant clears out_valid to 0. out_data and out_src keep their last values.
- Simultaneous drain and load in the same cycle gives a new word with out_valid staying 1. Full throughput is 1 word/cycle.
- Backpressure: while out_valid=1 & out_ready=0:
  - all in_ready=0;
  - out_data, out_src and out_valid are held stable;
  - last_grant is unchanged.
- last_grant updates only on an accepted transfer. Idle cycles or stalled cycles never move priority.
- Latency: 1 cycle from acceptance to out_valid.
- Fairness: with all 8 channels continuously valid and out_ready=1, grants cycle 0,1,...,7,0. Any continuously valid channel is served within 8 transfers.
- Protocol rules:
  - in_valid must not depend on in_ready. Once asserted, a source holds in_valid and in_data until accepted.
  - The grant may legally move to a newly valid higher-priority channel only before acceptance, never after.
- No combinational path from out_ready to out_valid. A path from out_ready/in_valid to in_ready is permitted.

Decomposition:
- Package rr_arb_pkg:
  - localparam NUM_CH=8;
  - localparam SEL_W=3;
  - typedef logic [SEL_W-1:0] ch_idx_t;
  - function rr_pick(valid[7:0], last ch_idx_t) returning {found, ch_idx_t}.
- Sub-module: instantiate the existing mux_8to1 (width=WIDTH) for the data path, with sel=grant_idx and d0..d7=in_data[0..7].
- Arbitration, pointer and output register are local to rr_arb_8to1.

Test Plan:
- Reset then single source: after reset, in_valid=8'b0000_0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=8'b0000_0100 in that cycle; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_src=2.
- All-request rotation: in_valid=8'hFF held, out_ready=1 for 9 cycles -> out_src sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles, out_valid continuously 1.
- Backpressure hold: word from channel 5 pending, out_ready=0 for 4 cycles with in_valid=8'hFF -> in_ready=0 throughout, out_data/out_src=5 stable; on out_ready=1 the next grant is channel 6.
- Sparse wrap-around: last_grant=6, in_valid=8'b0010_0001 -> channel 0 wins, then channel 5, then channel 0.
- Idle retains priority: grant channel 3, then in_valid=0 for 5 cycles, then in_valid=8'b0000_1001 -> channel 0 wins, because the pointer stayed at 3 and 4..7 are empty so the search wraps to 0.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0, out_data=0, out_src=0; with in_valid=8'h88 after release, channel 3 is granted first.
